// File: rtl/wbu_pkg.sv
// Shared widths for the write-back unit and its scoreboard.
// GPR index width and datapath width live here so both files agree.
package wbu_pkg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ISA_WIDTH      = 32;
endpackage

// File: rtl/wbu_scoreboard.sv
// Per-GPR busy bits: set on issue, cleared on the GPR commit edge.
// Three combinational lookups serve the IDU hazard checks.
module wbu_scoreboard
    import wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int NREG       = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy
);
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Set is applied after clear so a re-issue on the commit edge survives.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = (rs1_addr != '0) && busy[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && busy[rs2_addr];
    assign rd_busy  = (rd_addr  != '0) && busy[rd_addr];

    // A commit to a register nobody issued to means a producer invented a result.
    a_commit_was_issued: assert property (
        @(posedge clk) disable iff (!rst_n) clr_en |-> busy[clr_idx]
    );
endmodule

// File: rtl/wbu.sv
// Write-back unit: LSU-over-EXU arbitration into one registered GPR write port,
// plus the busy scoreboard the IDU uses to stall on pending writes.
module wbu
    import wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = ISA_WIDTH,
    parameter int NREG       = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic [DATA_WIDTH-1:0] gpr_w,
    output logic [ADDR_WIDTH-1:0] gpr_w_addr,
    output logic                  gpr_w_en
);
    logic                  lsu_acc;
    logic                  exu_acc;
    logic                  wb_valid;
    logic                  wb_write;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    assign lsu_ready = 1'b1;
    assign exu_ready = ~lsu_valid;

    assign lsu_acc  = lsu_valid;
    assign exu_acc  = exu_valid & ~lsu_valid;
    assign wb_valid = lsu_acc | exu_acc;
    assign wb_rd    = lsu_acc ? lsu_rd   : exu_rd;
    assign wb_data  = lsu_acc ? lsu_data : exu_data;
    // x0 results complete their handshake but never reach the register file.
    assign wb_write = wb_valid && (wb_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_w_en   <= 1'b0;
            gpr_w      <= '0;
            gpr_w_addr <= '0;
        end else begin
            gpr_w_en <= wb_write;
            if (wb_write) begin
                gpr_w      <= wb_data;
                gpr_w_addr <= wb_rd;
            end
        end
    end

    wbu_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NREG       (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (gpr_w_en),
        .clr_idx  (gpr_w_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (iss_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );
endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: a per-cycle reference model of busy bits and the
// write port, plus literal expectations at the key points of each scenario.
module tb_wbu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        exu_valid = 1'b0;
    logic        exu_ready;
    logic [4:0]  exu_rd = '0;
    logic [31:0] exu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic [31:0] gpr_w;
    logic [4:0]  gpr_w_addr;
    logic        gpr_w_en;

    int errors = 0;
    int checks = 0;

    wbu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_busy    (rd_busy),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .gpr_w      (gpr_w),
        .gpr_w_addr (gpr_w_addr),
        .gpr_w_en   (gpr_w_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the set of registers with a result still owed, and
    // the write the GPR port must present this cycle.
    bit          busy_m[32];
    bit          en_m = 1'b0;
    logic [4:0]  addr_m = '0;
    logic [31:0] data_m = '0;
    bit          known_m = 1'b1;

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        en_m = 1'b0;
        addr_m = '0;
        data_m = '0;
        known_m = 1'b1;
    end

    always @(posedge clk) begin
        if (rst_n) begin : model_step
            logic [4:0]  rd;
            logic [31:0] d;
            bit          took;
            took = 1'b1;
            if (lsu_valid) begin
                rd = lsu_rd; d = lsu_data;
            end else if (exu_valid) begin
                rd = exu_rd; d = exu_data;
            end else begin
                took = 1'b0; rd = '0; d = '0;
            end
            if (en_m) busy_m[addr_m] = 1'b0;
            if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
            if (took && rd != 0) begin
                en_m = 1'b1; addr_m = rd; data_m = d; known_m = 1'b1;
            end else begin
                en_m = 1'b0;
                if (took) known_m = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("lsu_ready", lsu_ready, 1);
            check("exu_ready", exu_ready, !lsu_valid);
            check("gpr_w_en", gpr_w_en, en_m);
            if (known_m) begin
                check("gpr_w_addr", gpr_w_addr, addr_m);
                check("gpr_w", gpr_w, data_m);
            end
            check("rs1_busy", rs1_busy, busy_m[rs1_addr]);
            check("rs2_busy", rs2_busy, busy_m[rs2_addr]);
            check("rd_busy", rd_busy, busy_m[iss_rd]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_gpr_w_en", gpr_w_en, 0);
        check("rst_gpr_w", gpr_w, 0);
        rst_n = 1'b1;
        tick();
        tick();
        for (int a = 0; a < 32; a += 7) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a); iss_rd = 5'(a);
            #1;
            check("idle_rs1_busy", rs1_busy, 0);
            check("idle_rs2_busy", rs2_busy, 0);
            check("idle_rd_busy", rd_busy, 0);
        end
        iss_rd = '0;

        // Issue x5, then EXU result for x5
        iss_valid = 1; iss_rd = 5; rs1_addr = 5;
        tick();
        iss_valid = 0;
        #1 check("x5_busy_after_issue", rs1_busy, 1);
        exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
        #1 check("x5_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 0;
        check("x5_w_en", gpr_w_en, 1);
        check("x5_w_addr", gpr_w_addr, 5);
        check("x5_w_data", gpr_w, 32'hDEADBEEF);
        check("x5_busy_until_commit", rs1_busy, 1);
        tick();
        check("x5_busy_cleared", rs1_busy, 0);
        check("x5_w_en_drop", gpr_w_en, 0);
        check("x5_w_hold", gpr_w, 32'hDEADBEEF);

        // LSU and EXU collide: LSU first, EXU next cycle
        iss_valid = 1; iss_rd = 3;
        tick();
        iss_rd = 4;
        tick();
        iss_valid = 0; rs1_addr = 3; rs2_addr = 4;
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h11;
        exu_valid = 1; exu_rd = 4; exu_data = 32'h22;
        #1 check("collide_exu_stalled", exu_ready, 0);
        tick();
        lsu_valid = 0;
        check("collide_w1_addr", gpr_w_addr, 3);
        check("collide_w1_data", gpr_w, 32'h11);
        #1 check("collide_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 0;
        check("collide_w2_en", gpr_w_en, 1);
        check("collide_w2_addr", gpr_w_addr, 4);
        check("collide_w2_data", gpr_w, 32'h22);
        tick();
        tick();
        check("collide_busy_cleared", rs1_busy | rs2_busy, 0);

        // Write and issue to x0
        exu_valid = 1; exu_rd = 0; exu_data = 32'hFFFFFFFF;
        iss_valid = 1; iss_rd = 0; rs1_addr = 0;
        #1 check("x0_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 0; iss_valid = 0;
        check("x0_no_write", gpr_w_en, 0);
        check("x0_not_busy", rs1_busy, 0);
        tick();

        // Same-edge set and clear on x7
        iss_valid = 1; iss_rd = 7; rs1_addr = 7;
        tick();
        iss_valid = 0;
        exu_valid = 1; exu_rd = 7; exu_data = 32'h77;
        tick();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 7;
        check("x7_commit_pending", gpr_w_en, 1);
        tick();
        iss_valid = 0;
        check("x7_set_wins", rs1_busy, 1);
        exu_valid = 1; exu_rd = 7; exu_data = 32'h78;
        tick();
        exu_valid = 0;
        tick();
        check("x7_final_clear", rs1_busy, 0);

        // Back-to-back writes, mixed producers
        for (int r = 10; r < 14; r++) begin
            iss_valid = 1; iss_rd = 5'(r);
            tick();
        end
        iss_valid = 0; rs1_addr = 12; rs2_addr = 13;
        for (int r = 10; r < 14; r++) begin
            lsu_valid = (r % 2 == 1);
            exu_valid = (r % 2 == 0);
            lsu_rd = 5'(r); lsu_data = 32'h100 + 32'(r);
            exu_rd = 5'(r); exu_data = 32'h200 + 32'(r);
            tick();
        end
        lsu_valid = 0; exu_valid = 0;
        check("b2b_last_addr", gpr_w_addr, 13);
        check("b2b_last_data", gpr_w, 32'h10D);
        tick();

        // Async reset with busy x9 and a write pending commit
        iss_valid = 1; iss_rd = 9; rs1_addr = 9;
        tick();
        iss_valid = 0;
        exu_valid = 1; exu_rd = 9; exu_data = 32'h99;
        tick();
        exu_valid = 0;
        check("rst_pre_en", gpr_w_en, 1);
        check("rst_pre_busy", rs1_busy, 1);
        #1 rst_n = 0;
        #1;
        check("rst_async_en", gpr_w_en, 0);
        check("rst_async_busy", rs1_busy, 0);
        check("rst_async_addr", gpr_w_addr, 0);
        check("rst_async_data", gpr_w, 0);
        exu_valid = 1; exu_rd = 9; exu_data = 32'hAA;
        iss_valid = 1; iss_rd = 9;
        tick();
        tick();
        check("rst_held_en", gpr_w_en, 0);
        check("rst_held_busy", rs1_busy, 0);
        exu_valid = 0; iss_valid = 0;
        #1 rst_n = 1;
        tick();
        tick();
        check("post_rst_en", gpr_w_en, 0);
        check("post_rst_busy", rs1_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
